sprite_bounce_engine: RTL and testbench
=======================================

Name: sprite_bounce_engine

Overview:
Per-frame motion engine for up to NUM_SPRITES independently bouncing sprites on a VGA raster. Once per frame it walks the sprite table sequentially, one sprite per clock. Each sprite moves by a programmable step, clamps and reflects at the screen edges, and advances its colour index on each bounce. It sits between vga_sync_generator (frame_tick source) and the pixel/ROM compositing logic, which consumes the packed position, direction and colour outputs.

Parameters:
NUM_SPRITES, 2, number of sprite slots (1..8)
DISPLAY_WIDTH, 640, visible width in pixels
DISPLAY_HEIGHT, 480, visible height in pixels
SPRITE_W, 128, sprite width; MAX_X = DISPLAY_WIDTH - SPRITE_W
SPRITE_H, 128, sprite height; MAX_Y = DISPLAY_HEIGHT - SPRITE_H
STEP_W, 3, width of speed input
COLOR_BITS, 3, width of per-sprite colour index
INIT_X, 200, reset x of sprite 0; sprite i resets to INIT_X + 32*i
INIT_Y, 200, reset y of every sprite

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse at start of frame
enable  in  1  0 = motion frozen; frame_tick ignored
speed  in  STEP_W  pixels moved per frame per axis; 0 = hold
load_valid  in  1  write one sprite slot
load_idx  in  clog2(NUM_SPRITES)  slot to write
load_x  in  10  new x
load_y  in  10  new y
load_dir  in  2  {dir_y, dir_x}; 1 = increasing coordinate
load_ready  out  1  high when a load is accepted (= ~busy)
pos_x  out  10*NUM_SPRITES  packed x; slot i at [10*i +: 10]
pos_y  out  10*NUM_SPRITES  packed y
dir_out  out  2*NUM_SPRITES  packed {dir_y, dir_x}
color_idx  out  COLOR_BITS*NUM_SPRITES  packed colour indices
busy  out  1  update sweep in progress
update_done  out  1  one-cycle pulse after the last sprite is written
bounce_pulse  out  NUM_SPRITES  one-cycle pulse: slot bounced on at least one axis
corner_pulse  out  NUM_SPRITES  one-cycle pulse: slot bounced on both axes in the same update
overrun  out  1  sticky; frame_tick arrived while busy

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sweep):
  - FSM enters IDLE; busy = 0; all pulses = 0; overrun = 0.
  - Slot i: x = INIT_X + 32*i, y = INIT_Y, dir_x = 1, dir_y = 0, color = i mod 2^COLOR_BITS.
  - Elaboration error if any reset position exceeds MAX_X/MAX_Y.
- FSM states:
  - IDLE -> SWEEP when frame_tick && enable; idx = 0; speed is sampled into step_r.
  - SWEEP: one slot is written per clock at idx.
    - idx == NUM_SPRITES-1 -> DONE; otherwise idx++.
  - DONE: update_done = 1 for one cycle -> IDLE.
- Timing: tick at edge t -> busy = 1 from t+1 through t+NUM_SPRITES+1; slot i is written at edge t+2+i.
- Per-axis arithmetic is done in 11 bits; there is no wrap-around:
  - Increasing direction: n = p + step. If n >= MAX, p = MAX, dir = 0, axis bounces.
  - Decreasing direction: if p <= step, p = 0, dir = 1, axis bounces; otherwise p = p - step.
  - step = 0: position held, no bounce, even at an edge.
- Colour: incremented by exactly 1 (mod 2^COLOR_BITS) if either axis bounced; never by 2.
- Pulses: bounce_pulse[i] and corner_pulse[i] are asserted in the cycle after slot i is written.
- Load: accepted only when load_ready.
  - x/y are clamped to MAX_X/MAX_Y; dir is written; colour is unchanged.
  - load_valid while busy is dropped silently.
  - load_idx >= NUM_SPRITES is ignored.
- Ticks during sweep:
  - frame_tick while busy: ignored; overrun is set to 1 and held until reset.
  - frame_tick with enable = 0: ignored; not an overrun.
- enable is sampled only at the tick; a sweep in progress completes regardless.

Decomposition:
- Package sprite_pkg:
  - DISPLAY_WIDTH/HEIGHT defaults and POS_W = 10.
  - Direction encoding (DIR_INC = 1, DIR_DEC = 0).
  - FSM state enum {IDLE, SWEEP, DONE}.
- Sub-module sprite_axis_step: combinational; inputs p, dir, step, max; outputs p_next, dir_next, bounced. Instantiated twice (x and y) on the idx-selected slot.

Test Plan:
1. Reset, NUM_SPRITES = 2 -> slot0 (200,200), slot1 (232,200), dir_out = 2'b01 each, colour 0/1, busy = 0.
2. speed = 1, one tick -> slot0 (201,199), slot1 (233,199); update_done exactly 3 cycles after busy rises; no bounce pulses.
3. Load slot0 x = 510, dir_x = 1; speed = 4; tick -> x = 512, dir_x = 0, bounce_pulse[0] = 1, corner_pulse[0] = 0, colour 0 -> 1.
4. Load slot1 (1,1), dir = 2'b00; speed = 2; tick -> (0,0), dir = 2'b11, corner_pulse[1] = 1, colour 1 -> 2 (not 3).
5. Tick, then a second tick and load_valid while busy -> second tick ignored, overrun = 1, load dropped. Load x = 700 in IDLE -> x = 512.
6. speed = 0 at x = 0, dir_x = 0 -> no movement, no bounce. Assert reset during SWEEP -> immediate reset values, busy = 0, no update_done.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite bounce engine.
package sprite_pkg;
    localparam int DISPLAY_WIDTH_DEF  = 640;
    localparam int DISPLAY_HEIGHT_DEF = 480;
    localparam int POS_W              = 10;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/sprite_axis_step.sv
// One-axis move with clamp and reflect at 0 and max; 11-bit arithmetic, no wrap.
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic [POS_W-1:0]  p,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [POS_W-1:0]  max,
    output logic [POS_W-1:0]  p_next,
    output logic              dir_next,
    output logic              bounced
);
    localparam int W1 = POS_W + 1;

    logic [W1-1:0] step_w;
    logic [W1-1:0] sum;

    always_comb begin
        step_w   = W1'(step);
        sum      = {1'b0, p} + step_w;
        p_next   = p;
        dir_next = dir;
        bounced  = 1'b0;
        // A zero step holds the sprite even when it sits on an edge.
        if (step != '0) begin
            if (dir == DIR_INC) begin
                if (sum >= {1'b0, max}) begin
                    p_next   = max;
                    dir_next = DIR_DEC;
                    bounced  = 1'b1;
                end else begin
                    p_next = sum[POS_W-1:0];
                end
            end else if ({1'b0, p} <= step_w) begin
                p_next   = '0;
                dir_next = DIR_INC;
                bounced  = 1'b1;
            end else begin
                p_next = p - POS_W'(step);
            end
        end
    end
endmodule

// File: rtl/sprite_bounce_engine.sv
// Per-frame motion engine: walks the sprite table one slot per clock after each frame tick.
//   state | meaning
//   IDLE  | waiting for frame_tick with enable; loads accepted
//   SWEEP | writing slot idx, one per clock
//   DONE  | last slot written; update_done follows next cycle
module sprite_bounce_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES    = 2,
    parameter int DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
    parameter int DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
    parameter int SPRITE_W       = 128,
    parameter int SPRITE_H       = 128,
    parameter int STEP_W         = 3,
    parameter int COLOR_BITS     = 3,
    parameter int INIT_X         = 200,
    parameter int INIT_Y         = 200,
    localparam int IDX_W         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_tick,
    input  logic                              enable,
    input  logic [STEP_W-1:0]                 speed,
    input  logic                              load_valid,
    input  logic [IDX_W-1:0]                  load_idx,
    input  logic [POS_W-1:0]                  load_x,
    input  logic [POS_W-1:0]                  load_y,
    input  logic [1:0]                        load_dir,
    output logic                              load_ready,
    output logic [POS_W*NUM_SPRITES-1:0]      pos_x,
    output logic [POS_W*NUM_SPRITES-1:0]      pos_y,
    output logic [2*NUM_SPRITES-1:0]          dir_out,
    output logic [COLOR_BITS*NUM_SPRITES-1:0] color_idx,
    output logic                              busy,
    output logic                              update_done,
    output logic [NUM_SPRITES-1:0]            bounce_pulse,
    output logic [NUM_SPRITES-1:0]            corner_pulse,
    output logic                              overrun
);
    localparam int MAX_X = DISPLAY_WIDTH - SPRITE_W;
    localparam int MAX_Y = DISPLAY_HEIGHT - SPRITE_H;
    localparam logic [POS_W-1:0] MAX_X_P = POS_W'(MAX_X);
    localparam logic [POS_W-1:0] MAX_Y_P = POS_W'(MAX_Y);

    if (NUM_SPRITES < 1 || NUM_SPRITES > 8) begin : g_bad_count
        $error("NUM_SPRITES must be 1..8");
    end
    if (INIT_X + 32*(NUM_SPRITES-1) > MAX_X || INIT_Y > MAX_Y) begin : g_bad_init
        $error("reset sprite position lies beyond the screen limits");
    end

    state_t state, state_nxt;
    logic                  start;
    logic [IDX_W-1:0]      idx;
    logic [STEP_W-1:0]     step_r;
    logic [POS_W-1:0]      x_r [NUM_SPRITES];
    logic [POS_W-1:0]      y_r [NUM_SPRITES];
    logic                  dx_r [NUM_SPRITES];
    logic                  dy_r [NUM_SPRITES];
    logic [COLOR_BITS-1:0] col_r [NUM_SPRITES];
    logic [POS_W-1:0]      nx, ny;
    logic                  ndx, ndy, bx, by;
    logic                  load_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick && enable) begin
                    state_nxt = SWEEP;
                    start     = 1'b1;
                end
            end
            SWEEP: begin
                if (idx == IDX_W'(NUM_SPRITES-1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign load_ready = ~busy;
    assign load_hit   = load_valid && !busy && (int'(load_idx) < NUM_SPRITES);

    sprite_axis_step #(.STEP_W(STEP_W)) u_step_x (
        .p(x_r[idx]), .dir(dx_r[idx]), .step(step_r), .max(MAX_X_P),
        .p_next(nx), .dir_next(ndx), .bounced(bx)
    );
    sprite_axis_step #(.STEP_W(STEP_W)) u_step_y (
        .p(y_r[idx]), .dir(dy_r[idx]), .step(step_r), .max(MAX_Y_P),
        .p_next(ny), .dir_next(ndy), .bounced(by)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_r[i]   <= POS_W'(INIT_X + 32*i);
                y_r[i]   <= POS_W'(INIT_Y);
                dx_r[i]  <= DIR_INC;
                dy_r[i]  <= DIR_DEC;
                col_r[i] <= COLOR_BITS'(i);
            end
            idx          <= '0;
            step_r       <= '0;
            bounce_pulse <= '0;
            corner_pulse <= '0;
            update_done  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            bounce_pulse <= '0;
            corner_pulse <= '0;
            update_done  <= (state == DONE);
            if (frame_tick && enable && busy) overrun <= 1'b1;
            if (start) begin
                idx    <= '0;
                step_r <= speed;
            end else if (state == SWEEP) begin
                x_r[idx]          <= nx;
                y_r[idx]          <= ny;
                dx_r[idx]         <= ndx;
                dy_r[idx]         <= ndy;
                // Corner hits still advance the colour by exactly one.
                if (bx || by) col_r[idx] <= col_r[idx] + 1'b1;
                bounce_pulse[idx] <= bx | by;
                corner_pulse[idx] <= bx & by;
                idx               <= idx + 1'b1;
            end
            if (load_hit) begin
                x_r[load_idx]  <= (load_x > MAX_X_P) ? MAX_X_P : load_x;
                y_r[load_idx]  <= (load_y > MAX_Y_P) ? MAX_Y_P : load_y;
                dx_r[load_idx] <= load_dir[0];
                dy_r[load_idx] <= load_dir[1];
            end
        end
    end

    always_comb begin
        pos_x     = '0;
        pos_y     = '0;
        dir_out   = '0;
        color_idx = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x[POS_W*i +: POS_W]               = x_r[i];
            pos_y[POS_W*i +: POS_W]               = y_r[i];
            dir_out[2*i +: 2]                     = {dy_r[i], dx_r[i]};
            color_idx[COLOR_BITS*i +: COLOR_BITS] = col_r[i];
        end
    end
endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Directed bench for sprite_bounce_engine with hand-computed expectations (2 sprites, 640x480).
module tb_sprite_bounce_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        enable;
    logic [2:0]  speed;
    logic        load_valid;
    logic [0:0]  load_idx;
    logic [9:0]  load_x, load_y;
    logic [1:0]  load_dir;
    logic        load_ready;
    logic [19:0] pos_x, pos_y;
    logic [3:0]  dir_out;
    logic [5:0]  color_idx;
    logic        busy, update_done, overrun;
    logic [1:0]  bounce_pulse, corner_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic [1:0] bseen, cseen;
    logic       done_seen;

    sprite_bounce_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .speed(speed),
        .load_valid(load_valid), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
        .load_dir(load_dir), .load_ready(load_ready), .pos_x(pos_x), .pos_y(pos_y),
        .dir_out(dir_out), .color_idx(color_idx), .busy(busy), .update_done(update_done),
        .bounce_pulse(bounce_pulse), .corner_pulse(corner_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic load(input logic idx, input int x, input int y, input logic [1:0] d);
        load_valid = 1'b1;
        load_idx   = idx;
        load_x     = 10'(x);
        load_y     = 10'(y);
        load_dir   = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Called on a negedge; returns cycles from busy rising to update_done.
    task automatic run_sweep(input logic [2:0] spd, output int l,
                             output logic [1:0] bs, output logic [1:0] cs);
        speed      = spd;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        l  = -1;
        bs = '0;
        cs = '0;
        check("busy_rise", busy, 1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bs |= bounce_pulse;
            cs |= corner_pulse;
            if (update_done) begin
                l = c;
                break;
            end
        end
        if (l < 0) check("sweep_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; speed = '0;
        load_valid = 1'b0; load_idx = '0; load_x = '0; load_y = '0; load_dir = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: reset state
        check("rst_x0", pos_x[9:0], 200);
        check("rst_x1", pos_x[19:10], 232);
        check("rst_y", pos_y, {10'd200, 10'd200});
        check("rst_dir", dir_out, 4'b0101);
        check("rst_col", color_idx, {3'd1, 3'd0});
        check("rst_busy", busy, 0);
        check("rst_ready", load_ready, 1);
        check("rst_overrun", overrun, 0);

        // 2: speed 1
        run_sweep(3'd1, lat, bseen, cseen);
        check("t2_latency", lat, 3);
        check("t2_x", pos_x, {10'd233, 10'd201});
        check("t2_y", pos_y, {10'd199, 10'd199});
        check("t2_bounce", bseen, 0);
        check("t2_dir", dir_out, 4'b0101);
        @(negedge clk);
        check("t2_idle", busy, 0);

        // 3: right-edge bounce on slot 0
        load(1'b0, 510, 199, 2'b01);
        run_sweep(3'd4, lat, bseen, cseen);
        check("t3_x", pos_x, {10'd237, 10'd512});
        check("t3_y", pos_y, {10'd195, 10'd195});
        check("t3_dir", dir_out, 4'b0100);
        check("t3_bounce", bseen, 2'b01);
        check("t3_corner", cseen, 2'b00);
        check("t3_col", color_idx, {3'd1, 3'd1});

        // 4: corner bounce on slot 1, colour +1 only
        load(1'b1, 1, 1, 2'b00);
        run_sweep(3'd2, lat, bseen, cseen);
        check("t4_x", pos_x, {10'd0, 10'd510});
        check("t4_y", pos_y, {10'd0, 10'd193});
        check("t4_dir", dir_out, 4'b1100);
        check("t4_bounce", bseen, 2'b10);
        check("t4_corner", cseen, 2'b10);
        check("t4_col", color_idx, {3'd2, 3'd1});

        // tick with enable low: ignored, no overrun
        enable = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("dis_busy", busy, 0);
        @(negedge clk);
        check("dis_overrun", overrun, 0);
        check("dis_x", pos_x, {10'd0, 10'd510});
        enable = 1'b1;

        // 5: tick and load while busy
        speed = 3'd2; frame_tick = 1'b1;
        @(negedge clk);
        check("t5_busy", busy, 1);
        check("t5_ready", load_ready, 0);
        load_valid = 1'b1; load_idx = 1'b0; load_x = 10'd5; load_y = 10'd5; load_dir = 2'b11;
        @(negedge clk);
        frame_tick = 1'b0; load_valid = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            if (update_done) done_seen = 1'b1;
            else @(negedge clk);
        end
        check("t5_done", done_seen, 1);
        check("t5_overrun", overrun, 1);
        check("t5_x", pos_x, {10'd2, 10'd508});
        check("t5_y", pos_y, {10'd2, 10'd191});
        check("t5_dir", dir_out, 4'b1100);
        done_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || update_done) done_seen = 1'b1;
        end
        check("t5_no_resweep", done_seen, 0);
        load(1'b0, 700, 100, 2'b01);
        check("t5_clamp_x", pos_x[9:0], 512);
        check("t5_load_y", pos_y[9:0], 100);
        check("t5_load_dir", dir_out[1:0], 2'b01);
        check("t5_overrun_held", overrun, 1);

        // 6: zero speed at the left edge
        load(1'b0, 0, 0, 2'b00);
        run_sweep(3'd0, lat, bseen, cseen);
        check("t6_x", pos_x, {10'd2, 10'd0});
        check("t6_y", pos_y, {10'd2, 10'd0});
        check("t6_dir", dir_out, 4'b1100);
        check("t6_bounce", bseen, 0);
        check("t6_col", color_idx, {3'd2, 3'd1});

        // reset mid-sweep
        speed = 3'd3; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("t6_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_x", pos_x, {10'd232, 10'd200});
        check("mr_y", pos_y, {10'd200, 10'd200});
        check("mr_dir", dir_out, 4'b0101);
        check("mr_col", color_idx, {3'd1, 3'd0});
        check("mr_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (update_done || busy) done_seen = 1'b1;
        end
        check("mr_no_done", done_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
